// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating counters indexed by PC, producing the
// fetch-stage 'taken' hint and a registered mispredict/redirect request when
// execute resolves a conditional branch against the prediction it was fetched with.
// Optional build macro: BHT_BYPASS_EN forwards a same-cycle counter update to 'taken'.
module branch_history_table #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          INDEX_WIDTH = 6,
    parameter logic [1:0]  INIT_STATE  = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] query_pc,
    output logic                  taken,
    input  logic                  resolve_valid,
    input  logic [DATA_WIDTH-1:0] resolve_pc,
    input  logic                  resolve_taken,
    input  logic                  resolve_predicted,
    input  logic [DATA_WIDTH-1:0] resolve_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_addr
);

    localparam int                  ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic [1:0]             counters [ENTRIES];
    logic [INDEX_WIDTH-1:0] query_idx;
    logic [INDEX_WIDTH-1:0] resolve_idx;
    logic                   accept;
    logic [1:0]             resolve_count;
    logic [1:0]             next_count;
    logic                   unused_query_bits;

    assign query_idx   = query_pc[INDEX_WIDTH+1:2];
    assign resolve_idx = resolve_pc[INDEX_WIDTH+1:2];

    // Only tag-less index bits select an entry; the rest of the query PC is ignored.
    assign unused_query_bits = ^{query_pc[DATA_WIDTH-1:INDEX_WIDTH+2], query_pc[1:0]};

    // A resolve arriving while the flush pulse is high belongs to the wrong path.
    assign accept        = resolve_valid && !mispredict;
    assign resolve_count = counters[resolve_idx];

    // Saturating increment/decrement of the resolved branch's counter.
    always_comb begin
        // NOTE: default first so every path assigns next_count and no latch is inferred.
        next_count = resolve_count;
        if (resolve_taken) begin
            if (resolve_count != 2'b11) next_count = resolve_count + 2'b01;
        end else begin
            if (resolve_count != 2'b00) next_count = resolve_count - 2'b01;
        end
    end

`ifdef BHT_BYPASS_EN
    // Forward the post-update counter when the query hits the entry being trained.
    always_comb begin
        taken = counters[query_idx][1];
        if (accept && (query_idx == resolve_idx)) taken = next_count[1];
    end
`else
    // Prediction from the stored counter; an update becomes visible next cycle.
    always_comb begin
        taken = counters[query_idx][1];
    end
`endif

    // Counter table: small flop array, cleared to INIT_STATE on reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the table is built from flops rather than a RAM, so it can and must be reset.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) counters[i] <= INIT_STATE;
        end else if (accept) begin
            // NOTE: non-blocking so the table updates together with the other state at the edge.
            counters[resolve_idx] <= next_count;
        end
    end

    // Registered flush pulse and correct next PC for fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict    <= 1'b0;
            redirect_addr <= '0;
        end else if (accept && (resolve_taken != resolve_predicted)) begin
            mispredict    <= 1'b1;
            redirect_addr <= resolve_taken ? resolve_target : resolve_pc + PC_STEP;
        end else begin
            mispredict    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: reset sweep, a table of
// resolve vectors with expected prediction/redirect results (scoreboarded),
// and hand-written sequences for wrong-path resolves, same-cycle bypass and
// asynchronous reset during a flush pulse.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] query_pc = '0;
    logic        taken;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic        resolve_predicted = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        mispredict;
    logic [31:0] redirect_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        act;
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] qpc;
        logic        exp_taken;
        logic        exp_mis;
        logic [31:0] exp_redir;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    branch_history_table dut (
        .clk               (clk),
        .rst               (rst),
        .query_pc          (query_pc),
        .taken             (taken),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_taken     (resolve_taken),
        .resolve_predicted (resolve_predicted),
        .resolve_target    (resolve_target),
        .mispredict        (mispredict),
        .redirect_addr     (redirect_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic mis, input logic [31:0] redir);
        exp_t e;
        e.mis   = mis;
        e.redir = redir;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, ".mispredict"}, {31'b0, mispredict}, {31'b0, e.mis});
            check({name, ".redirect"}, redirect_addr, e.redir);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;

        // Stimulus table: each resolve is followed by one idle cycle.
        vecs[0]  = '{32'h0000_0014, 1'b1, 1'b1, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0014, 1'b1, 1'b1, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{32'h0000_0014, 1'b1, 1'b1, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{32'h0000_0014, 1'b0, 1'b0, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{32'h0000_0114, 1'b0, 1'b0, 32'h0,         32'h0000_0014, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200};
        vecs[6]  = '{32'h0000_0100, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0104};
        vecs[7]  = '{32'h0000_0100, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
        vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0500, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{32'h0000_003C, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0000_003C, 1'b1, 1'b1, 32'h0000_ABCD};
        vecs[10] = '{32'h0000_00FC, 1'b1, 1'b1, 32'h0,         32'h0000_00FC, 1'b0, 1'b0, 32'h0000_ABCD};
        vecs[11] = '{32'h0000_0017, 1'b1, 1'b1, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 32'h0000_ABCD};

        // Reset state: every entry weakly not-taken, outputs cleared.
        #1;
        for (int a = 0; a < 'h100; a += 4) begin
            query_pc = a;
            #1;
            check($sformatf("reset.taken[%0h]", a), {31'b0, taken}, 32'h0);
        end
        check("reset.mispredict", {31'b0, mispredict}, 32'h0);
        check("reset.redirect", redirect_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table-driven resolves.
        held = 32'h0;
        for (int i = 0; i < 12; i++) begin
            resolve_valid     = 1'b1;
            resolve_pc        = vecs[i].pc;
            resolve_taken     = vecs[i].act;
            resolve_predicted = vecs[i].pred;
            resolve_target    = vecs[i].tgt;
            query_pc          = vecs[i].qpc;
            push_exp(vecs[i].exp_mis, vecs[i].exp_redir);
            held = vecs[i].exp_redir;
            step();
            resolve_valid = 1'b0;
            #1;
            compare_out($sformatf("vec%0d", i));
            check($sformatf("vec%0d.taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
            push_exp(1'b0, held);
            step();
            compare_out($sformatf("vec%0d.idle", i));
        end

        // Wrong-path resolve during the flush pulse is ignored.
        resolve_valid = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1;
        resolve_predicted = 1'b0; resolve_target = 32'h500;
        push_exp(1'b1, 32'h500);
        step();
        compare_out("wrongpath.setup");
        resolve_pc = 32'h20; resolve_taken = 1'b1; resolve_predicted = 1'b0;
        resolve_target = 32'h900;
        push_exp(1'b0, 32'h500);
        step();
        resolve_valid = 1'b0;
        query_pc = 32'h20;
        #1;
        compare_out("wrongpath");
        check("wrongpath.entry", {31'b0, taken}, 32'h0);

        // Same-cycle query and training on a fresh entry.
        step();
        query_pc = 32'h40; resolve_pc = 32'h40; resolve_valid = 1'b1;
        resolve_taken = 1'b1; resolve_predicted = 1'b1;
        #1;
`ifdef BHT_BYPASS_EN
        check("bypass.same_cycle", {31'b0, taken}, 32'h1);
`else
        check("bypass.same_cycle", {31'b0, taken}, 32'h0);
`endif
        step();
        resolve_valid = 1'b0;
        #1;
        check("bypass.next_cycle", {31'b0, taken}, 32'h1);
        check("bypass.no_pulse", {31'b0, mispredict}, 32'h0);

        // Asynchronous reset in the middle of a flush pulse.
        resolve_valid = 1'b1; resolve_pc = 32'h80; resolve_taken = 1'b0;
        resolve_predicted = 1'b1; resolve_target = 32'h0;
        step();
        resolve_valid = 1'b0;
        check("rstpulse.pre", {31'b0, mispredict}, 32'h1);
        check("rstpulse.pre_redirect", redirect_addr, 32'h84);
        #2;
        rst = 1'b1;
        #1;
        check("rstpulse.mispredict", {31'b0, mispredict}, 32'h0);
        check("rstpulse.redirect", redirect_addr, 32'h0);
        query_pc = 32'h14; #1;
        check("rstpulse.entry14", {31'b0, taken}, 32'h0);
        query_pc = 32'h40; #1;
        check("rstpulse.entry40", {31'b0, taken}, 32'h0);
        query_pc = 32'h3C; #1;
        check("rstpulse.entry3c", {31'b0, taken}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
